// File: rtl/vga_fade_pkg.sv
// Shared definitions for the scene fader: fade state encoding and the
// pixel/colour geometry constants used by the fader, its channel scaler
// and its bus interface.
package vga_fade_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam int RGB_W    = 12;
    localparam int CH_W     = 4;
    localparam int LVL_MAX  = 15;
    localparam int COORD_W  = 10;
    localparam int BAR_H    = 8;
    localparam int BAR_UNIT = 16;

endpackage

// File: rtl/vga_scene_fader_if.sv
// Pixel-stream bundle around the scene fader.
//   choise     : raw scene select from the board switches (asynchronous)
//   pixel_x/y  : current coordinates from vga_driver
//   src_data   : RGB444 from the background generator
//   scene_sel  : scene index back to the background generator
//   pixel_data : faded RGB444 to vga_driver
//   busy/level : fade status for debug/LEDs
// master = the surrounding system, slave = the fader.
interface vga_scene_fader_if #(
    parameter int LVL_W = 4
);
    import vga_fade_pkg::*;

    logic [1:0]         choise;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [RGB_W-1:0]   src_data;
    logic [1:0]         scene_sel;
    logic [RGB_W-1:0]   pixel_data;
    logic               busy;
    logic [LVL_W-1:0]   level;

    modport master (
        output choise, pixel_x, pixel_y, src_data,
        input  scene_sel, pixel_data, busy, level
    );

    modport slave (
        input  choise, pixel_x, pixel_y, src_data,
        output scene_sel, pixel_data, busy, level
    );

endinterface

// File: rtl/vga_chan_scale.sv
// Combinational brightness scaler for one colour channel.
//   chan_in  : channel intensity
//   level    : brightness level, all-ones means full brightness
//   chan_out : (chan_in * level) >> LVL_W, or chan_in unchanged at full level
module vga_chan_scale
    import vga_fade_pkg::*;
#(
    parameter int LVL_W = 4
) (
    input  logic [CH_W-1:0]  chan_in,
    input  logic [LVL_W-1:0] level,
    output logic [CH_W-1:0]  chan_out
);

    logic [CH_W+LVL_W-1:0] prod;

    assign prod = {{LVL_W{1'b0}}, chan_in} * {{CH_W{1'b0}}, level};

    // The shift alone would give 15*15>>4 = 14 at full level, so full
    // level bypasses the multiplier to keep the picture exact when idle.
    assign chan_out = (level == {LVL_W{1'b1}}) ? chan_in : prod[LVL_W +: CH_W];

endmodule

// File: rtl/vga_scene_fader.sv
// Scene fader between the background generator and vga_driver. Owns the
// scene selection: a change on choise fades the picture to black, switches
// scene_sel, then fades back in, one brightness step per FRAMES_PER_STEP
// frames. pixel_data is registered, one vga_clk behind the inputs.
//
// Ports:
//   vga_clk   : pixel clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : vga_scene_fader_if.slave (choise, pixel_x/y, src_data in;
//               scene_sel, pixel_data, busy, level out)
//
// Build option: define VGA_FADE_LEVEL_BAR_EN to overlay a white bar of
// width level*16 px in the top 8 rows showing the current level.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | full brightness, watching for a new scene selection
// FADE_OUT | stepping level down to 0, target follows the switches
// SWITCH   | one cycle at black: scene_sel takes the target
// FADE_IN  | stepping level back up to full, switches ignored
module vga_scene_fader
    import vga_fade_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int LVL_W           = 4
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    vga_scene_fader_if.slave  bus
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = '1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    fade_state_t       state_q, state_d;
    logic [1:0]        ch_meta, ch_s;
    logic [1:0]        target_q, target_d;
    logic [1:0]        scene_q, scene_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              origin, prev_origin, frame_tick, fading, step;
    logic [RGB_W-1:0]  scaled, pix_d, pix_q;

    // Coordinates sit at (0,0) through blanking; only the first cycle there
    // counts as the frame tick.
    assign origin     = (bus.pixel_x == '0) && (bus.pixel_y == '0);
    assign frame_tick = origin & ~prev_origin;
    assign fading     = (state_q == FADE_OUT) || (state_q == FADE_IN);
    assign step       = fading && frame_tick && (cnt_q == CNT_LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ch_meta     <= '0;
            ch_s        <= '0;
            prev_origin <= 1'b0;
        end else begin
            ch_meta     <= bus.choise;
            ch_s        <= ch_meta;
            prev_origin <= origin;
        end
    end

    // Held at zero outside the fades, so it restarts on every fade entry.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (!fading) begin
            cnt_q <= '0;
        end else if (frame_tick) begin
            cnt_q <= step ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        scene_d  = scene_q;
        case (state_q)
            IDLE: begin
                if (ch_s != scene_q) begin
                    target_d = ch_s;
                    state_d  = FADE_OUT;
                end
            end
            FADE_OUT: begin
                target_d = ch_s;
                if (step) begin
                    level_d = level_q - LVL_ONE;
                    if (level_q == LVL_ONE) begin
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                // Even if the user switched back, the fade-in still runs.
                scene_d = target_q;
                state_d = FADE_IN;
            end
            FADE_IN: begin
                if (step) begin
                    level_d = level_q + LVL_ONE;
                    if (level_q == LVL_FULL - LVL_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        vga_chan_scale #(.LVL_W(LVL_W)) u_scale (
            .chan_in  (bus.src_data[c*CH_W +: CH_W]),
            .level    (level_q),
            .chan_out (scaled[c*CH_W +: CH_W])
        );
    end

`ifdef VGA_FADE_LEVEL_BAR_EN
    logic [COORD_W-1:0] bar_w;
    logic               in_bar;

    assign bar_w  = COORD_W'(level_q) * COORD_W'(BAR_UNIT);
    assign in_bar = (bus.pixel_y < COORD_W'(BAR_H)) && (bus.pixel_x < bar_w);
    assign pix_d  = in_bar ? {RGB_W{1'b1}} : scaled;
`else
    assign pix_d  = scaled;
`endif

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_q  <= LVL_FULL;
            target_q <= '0;
            scene_q  <= '0;
            pix_q    <= '0;
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
            scene_q  <= scene_d;
            pix_q    <= pix_d;
        end
    end

    assign bus.scene_sel  = scene_q;
    assign bus.pixel_data = pix_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.level      = level_q;

endmodule

// File: tb/tb_vga_scene_fader.sv
// Bench for vga_scene_fader: two instances (1 and 2 frames per step) share
// the same stimulus; a fade-progress model checks both every cycle and
// directed literal checks pin the single-step instance.
module tb_vga_scene_fader;

    logic       vga_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [1:0] choise;
    logic [9:0] px, py;
    logic [11:0] src;

    int total = 0;
    int bad   = 0;

    always #20 vga_clk = ~vga_clk;

    vga_scene_fader_if bus0 ();
    vga_scene_fader_if bus1 ();

    assign bus0.choise   = choise;
    assign bus0.pixel_x  = px;
    assign bus0.pixel_y  = py;
    assign bus0.src_data = src;
    assign bus1.choise   = choise;
    assign bus1.pixel_x  = px;
    assign bus1.pixel_y  = py;
    assign bus1.src_data = src;

    vga_scene_fader #(.FRAMES_PER_STEP(1)) dut0 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus0.slave)
    );

    vga_scene_fader #(.FRAMES_PER_STEP(2)) dut1 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus1.slave)
    );

    int o_pix[2], o_lvl[2], o_busy[2], o_scene[2];
    always_comb begin
        o_pix[0]   = int'(bus0.pixel_data);
        o_pix[1]   = int'(bus1.pixel_data);
        o_lvl[0]   = int'(bus0.level);
        o_lvl[1]   = int'(bus1.level);
        o_busy[0]  = int'(bus0.busy);
        o_busy[1]  = int'(bus1.busy);
        o_scene[0] = int'(bus0.scene_sel);
        o_scene[1] = int'(bus1.scene_sel);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Brightness as a function of steps taken k in the current fade:
    // 15 steps down to black, then 15 steps back up.
    function automatic int lvl_of(input int k);
        return (k <= 15) ? 15 - k : k - 15;
    endfunction

    function automatic int scale_px(input int rgb, input int lv);
        int r = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int c = (rgb >> (4 * ch)) & 15;
            int o = (lv == 15) ? c : (c * lv) / 16;
            r = r | (o << (4 * ch));
        end
        return r;
    endfunction

    function automatic int expect_pix(input int rgb, input int lv, input int x, input int y);
`ifdef VGA_FADE_LEVEL_BAR_EN
        if (y < 8 && x < lv * 16) return 'hFFF;
`endif
        return scale_px(rgb, lv);
    endfunction

    // Model: per instance, whether a fade is active, steps taken, frames
    // since last step, pending scene switch, and the synchronised select.
    int m_s1[2], m_s2[2], m_prev[2], m_act[2], m_k[2], m_sw[2];
    int m_fr[2], m_scene[2], m_tgt[2], m_pix[2];

    always @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_prev[i] = 0; m_act[i] = 0;
                m_k[i] = 0; m_sw[i] = 0; m_fr[i] = 0; m_scene[i] = 0;
                m_tgt[i] = 0; m_pix[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int origin, tick, fps;
                fps    = (i == 0) ? 1 : 2;
                origin = (px == 0 && py == 0) ? 1 : 0;
                tick   = (origin == 1 && m_prev[i] == 0) ? 1 : 0;
                m_pix[i] = expect_pix(int'(src), lvl_of(m_k[i]), int'(px), int'(py));
                if (m_act[i] == 0) begin
                    if (m_s2[i] != m_scene[i]) begin
                        m_act[i] = 1; m_k[i] = 0; m_fr[i] = 0; m_tgt[i] = m_s2[i];
                    end
                end else if (m_sw[i] == 1) begin
                    m_scene[i] = m_tgt[i]; m_sw[i] = 0; m_fr[i] = 0;
                end else begin
                    if (m_k[i] < 15) m_tgt[i] = m_s2[i];
                    if (tick == 1) begin
                        if (m_fr[i] == fps - 1) begin
                            m_fr[i] = 0;
                            m_k[i]++;
                            if (m_k[i] == 15) m_sw[i] = 1;
                            if (m_k[i] == 30) m_act[i] = 0;
                        end else begin
                            m_fr[i]++;
                        end
                    end
                end
                m_s2[i]   = m_s1[i];
                m_s1[i]   = int'(choise);
                m_prev[i] = origin;
            end
        end
    end

    always @(negedge vga_clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_pix%0d", i),   o_pix[i],   m_pix[i]);
            chk($sformatf("model_level%0d", i), o_lvl[i],   lvl_of(m_k[i]));
            chk($sformatf("model_busy%0d", i),  o_busy[i],  m_act[i]);
            chk($sformatf("model_scene%0d", i), o_scene[i], m_scene[i]);
        end
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic origin_cycle();
        px = 0; py = 0;
        cyc();
        px = 1;
    endtask

    task automatic tick();
        origin_cycle();
        cyc();
        cyc();
    endtask

    initial begin
        choise = 0; px = 1; py = 1; src = 12'hABC;
        #1 sys_rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_pix",   o_pix[0],   0);
        chk("rst_level", o_lvl[0],   15);
        chk("rst_scene", o_scene[0], 0);
        chk("rst_busy",  o_busy[0],  0);
        sys_rst_n = 1'b1;
        cyc();
        chk("release_pix", o_pix[0], 'hABC);
        cyc();

        // fade out to scene 2
        choise = 2; src = 12'hFFF;
        cyc(); cyc();
        chk("busy_pre", o_busy[0], 0);
        cyc();
        chk("busy_rise", o_busy[0], 1);
        repeat (7) tick();
        chk("lvl8", o_lvl[0], 8);
        chk("pix777", o_pix[0], 'h777);
        repeat (7) tick();
        chk("lvl1", o_lvl[0], 1);
        origin_cycle();
        chk("lvl0", o_lvl[0], 0);
        chk("scene_pre_sw", o_scene[0], 0);
        cyc();
        chk("scene_sw", o_scene[0], 2);
        chk("pix000", o_pix[0], 0);
        cyc();

        // fade in
        repeat (14) tick();
        chk("lvl14", o_lvl[0], 14);
        chk("busy_in", o_busy[0], 1);
        origin_cycle();
        chk("lvl15", o_lvl[0], 15);
        chk("busy_done", o_busy[0], 0);
        cyc();
        chk("pixFFF", o_pix[0], 'hFFF);

        // retarget during fade-out, change during fade-in
        src = 12'h5A3; choise = 1;
        repeat (3) cyc();
        repeat (5) tick();
        chk("rt_lvl10", o_lvl[0], 10);
        choise = 3;
        repeat (3) cyc();
        repeat (9) tick();
        origin_cycle();
        chk("rt_lvl0", o_lvl[0], 0);
        cyc();
        chk("rt_scene3", o_scene[0], 3);
        cyc();
        repeat (3) tick();
        choise = 0;
        repeat (11) tick();
        chk("rt_lvl14", o_lvl[0], 14);
        origin_cycle();
        chk("rt_idle_busy", o_busy[0], 0);
        chk("rt_idle_scene", o_scene[0], 3);
        cyc();
        chk("rt_restart", o_busy[0], 1);
        repeat (30) tick();
        chk("rt2_scene0", o_scene[0], 0);
        chk("rt2_busy", o_busy[0], 0);
        chk("rt2_lvl", o_lvl[0], 15);

        // origin held through blanking, then reset mid-fade
        choise = 1;
        repeat (3) cyc();
        px = 0; py = 0;
        repeat (100) cyc();
        px = 1;
        cyc();
        chk("blank_lvl14", o_lvl[0], 14);
        repeat (8) tick();
        chk("mid_lvl6", o_lvl[0], 6);
        sys_rst_n = 1'b0;
        #1;
        chk("rm_level", o_lvl[0], 15);
        chk("rm_scene", o_scene[0], 0);
        chk("rm_busy",  o_busy[0], 0);
        chk("rm_pix",   o_pix[0], 0);
        choise = 0;
        repeat (2) cyc();
        sys_rst_n = 1'b1;
        cyc();

        // level bar region at level 4
        choise = 2; src = 12'hABC;
        repeat (3) cyc();
        repeat (11) tick();
        chk("bar_lvl4", o_lvl[0], 4);
        px = 63; py = 3;
        cyc();
`ifdef VGA_FADE_LEVEL_BAR_EN
        chk("bar_63_3", o_pix[0], 'hFFF);
`else
        chk("bar_63_3", o_pix[0], 'h223);
`endif
        px = 64;
        cyc();
        chk("bar_64_3", o_pix[0], 'h223);
        px = 10; py = 8;
        cyc();
        chk("bar_10_8", o_pix[0], 'h223);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scene_fader.md
Name: vga_scene_fader

Overview:
- Pixel-domain stage between the background generator (vga_display_back) and vga_driver.
- Owns the scene selection: it registers the user scene-select input and drives `scene_sel` to the background generator.
- On a scene change it fades the picture to black, switches scene, then fades back in, stepping brightness once per N frames.
- Passes the faded 12-bit RGB444 `pixel_data` on to vga_driver.

Parameters:
- FRAMES_PER_STEP, 2, frames per brightness step (≥1).
- LVL_W, 4, brightness level width; full level = 2**LVL_W-1 = 15.

Ports:
- vga_clk  in  1  25 MHz pixel clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- choise  in  2  scene select from board switches (asynchronous).
- pixel_x  in  10  current pixel column from vga_driver.
- pixel_y  in  10  current pixel row from vga_driver.
- src_data  in  12  RGB444 from background generator for (pixel_x, pixel_y).
- scene_sel  out  2  scene index driven to background generator.
- pixel_data  out  12  faded RGB444 to vga_driver.
- busy  out  1  high while a fade is in progress.
- level  out  4  current brightness level (debug/LED).

Behaviour:
- Reset values (all asynchronous on sys_rst_n low, including mid-fade):
  - state=IDLE, level=15, scene_sel=0, target=0, pixel_data=0, busy=0.
  - step counter=0, synchroniser flops=0, prev_origin=0.
- `choise` passes through a 2-flop synchroniser → `ch_s` (2-cycle latency).
- Frame tick:
  - origin = (pixel_x==0 && pixel_y==0); prev_origin is the registered copy of origin.
  - frame_tick = origin & ~prev_origin, one cycle per frame even though coordinates hold at 0 through blanking.
- Step tick:
  - On frame_tick in FADE_OUT or FADE_IN: if cnt==FRAMES_PER_STEP-1 then step=1 and cnt=0, else cnt+1.
  - cnt is cleared on entry to FADE_OUT and FADE_IN.
- State machine (2-bit):
  - IDLE:
    - if ch_s != scene_sel, latch target=ch_s and go to FADE_OUT.
    - busy=0.
  - FADE_OUT:
    - target tracks ch_s every cycle, so the last selection wins.
    - on step, level -= 1.
    - when a step takes level from 1 to 0, go to SWITCH.
  - SWITCH: for exactly 1 cycle, scene_sel <= target, then go to FADE_IN.
  - FADE_IN:
    - on step, level += 1; when a step takes level 14→15, go to IDLE.
    - ch_s changes are ignored until IDLE.
    - IDLE re-compares next cycle, so a change during fade-in starts a new fade immediately after.
  - busy=1 in FADE_OUT, SWITCH and FADE_IN.
  - If target==scene_sel at SWITCH (user switched back), still complete the fade-in; no shortcut.
- Fade duration: 15 steps out + 15 steps in = 30·FRAMES_PER_STEP frames (±1 frame of tick alignment).
- Scaling, per channel c (4 bits):
  - level==15 → c, exact pass-through.
  - otherwise (c·level)>>4, using an 8-bit product.
  - level==0 → 0.
- Latency: pixel_data is registered, 1 vga_clk after src_data/pixel_x/pixel_y; vga_driver's coordinate lookahead absorbs this.
- level changes only on step ticks, which fall at frame origin, so there is no mid-frame tearing.
- FRAMES_PER_STEP==1: every frame_tick is a step.

Optional Feature:
- Macro: VGA_FADE_LEVEL_BAR_EN.
- Defined:
  - for pixel_y<8 and pixel_x < level·16, pixel_data = 12'hFFF, unscaled, overriding the faded data.
  - The bar shows the current level; max width 240 px.
  - Same 1-cycle latency.
- Undefined: no overlay; logic absent.

Decomposition:
- Package vga_fade_pkg:
  - state encoding IDLE=0, FADE_OUT=1, SWITCH=2, FADE_IN=3.
  - RGB_W=12, CH_W=4, LVL_MAX=15, COORD_W=10, BAR_H=8, BAR_UNIT=16.
- Sub-module vga_chan_scale: combinational 4-bit channel × level scaler with the level==15 bypass; instantiated 3× (R, G, B).

Test Plan:
- Reset: hold sys_rst_n=0 with src_data=12'hABC → pixel_data=0, level=15, scene_sel=0, busy=0. Release → pixel_data=12'hABC one cycle after the next sample.
- Fade out: FRAMES_PER_STEP=1, choise 0→2 → busy rises 3 cycles later; level 15→0 over 15 frame ticks; at level 8, src 12'hFFF → pixel_data 12'h777; at level 0 → 12'h000.
- Switch and fade in:
  - scene_sel becomes 2 exactly one cycle after level hits 0.
  - level climbs to 15 over 15 ticks, then busy drops.
  - Total span is 30 frame ticks.
- Retarget: choise 0→1, then →3 while level=10 in FADE_OUT → scene_sel ends at 3; choise→0 during FADE_IN → a second fade starts the cycle after IDLE, ending with scene_sel=0.
- Blanking tick / reset mid-fade:
  - pixel_x=pixel_y=0 held for 100 cycles → one step only.
  - Assert reset at level=6 → immediate return to level=15, scene_sel=0, IDLE.
- VGA_FADE_LEVEL_BAR_EN: at level=4, pixel (63,3) → 12'hFFF; (64,3) and (10,8) → scaled src_data.
